// File: rtl/sid_voice_synth.sv
// sid_voice_synth: three-voice SID-style synthesizer core.
// Contains the register file, three 24-bit phase accumulators with noise LFSRs,
// linear ADSR envelopes and a volume-scaled mixer. There is no analog filter.
// Optional feature macro: SID_READBACK_EN adds a registered rdata port
// that exposes OSC3 at 0x1B and ENV3 at 0x1C.
module sid_voice_synth #(
  parameter logic [22:0] NOISE_SEED = 23'h7FFFF8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [4:0]  addr,
  input  logic [7:0]  data,
  input  logic        n_cs,
  input  logic        rw,
  output logic [15:0] audio_out
`ifdef SID_READBACK_EN
  ,
  output logic [7:0]  rdata
`endif
);

  localparam logic [1:0] ST_ATTACK  = 2'd0;
  localparam logic [1:0] ST_DECAY   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Envelope step period, in clk_en ticks, for a 4-bit rate code.
  function automatic logic [14:0] rate_period(input logic [3:0] rate);
    logic [14:0] p;
    case (rate)
      4'd0:    p = 15'd9;
      4'd1:    p = 15'd32;
      4'd2:    p = 15'd63;
      4'd3:    p = 15'd95;
      4'd4:    p = 15'd149;
      4'd5:    p = 15'd220;
      4'd6:    p = 15'd267;
      4'd7:    p = 15'd313;
      4'd8:    p = 15'd392;
      4'd9:    p = 15'd977;
      4'd10:   p = 15'd1954;
      4'd11:   p = 15'd3126;
      4'd12:   p = 15'd3907;
      4'd13:   p = 15'd11720;
      4'd14:   p = 15'd19532;
      default: p = 15'd31251;
    endcase
    return p;
  endfunction

  logic [7:0]  regs_q [25];
  logic        acc_msb [3];
  logic        acc_rise [3];
  logic [11:0] voice_v [3];
`ifdef SID_READBACK_EN
  logic [11:0] wave_out [3];
  logic [7:0]  env_out [3];
`endif

  // Register file: CPU writes land on any clock, independent of clk_en; 0x19-0x1F have no storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 25; i++) regs_q[i] <= 8'd0;
    end else if (!n_cs && !rw && addr <= 5'h18) begin
      regs_q[addr] <= data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_voice
      localparam int B   = 7 * gi;
      localparam int SRC = (gi + 2) % 3;

      logic [15:0] freq;
      logic [11:0] pw;
      logic [7:0]  ctrl, ad, sr;
      assign freq = {regs_q[B+1], regs_q[B]};
      assign pw   = {regs_q[B+3][3:0], regs_q[B+2]};
      assign ctrl = regs_q[B+4];
      assign ad   = regs_q[B+5];
      assign sr   = regs_q[B+6];

      // ---------------- oscillator ----------------
      logic [23:0] acc_q, acc_d, acc_sum;
      logic [22:0] lfsr_q, lfsr_d;

      // Free-running phase sum; TEST pins the accumulator at zero.
      always_comb begin
        acc_sum = ctrl[3] ? 24'd0 : acc_q + {8'd0, freq};
      end

      assign acc_msb[gi]  = acc_q[23];
      assign acc_rise[gi] = ~acc_q[23] & acc_sum[23];

      // Hard sync clears this voice when the source MSB rises in the same tick.
      always_comb begin
        acc_d = (ctrl[1] && acc_rise[SRC]) ? 24'd0 : acc_sum;
      end

      // Noise LFSR clocks on a rising accumulator bit 19; TEST reloads the seed.
      always_comb begin
        lfsr_d = lfsr_q;
        if (ctrl[3])
          lfsr_d = NOISE_SEED;
        else if (!acc_q[19] && acc_d[19])
          lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
      end

      // Oscillator state advances on the clk_en strobe only.
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q  <= 24'd0;
          lfsr_q <= NOISE_SEED;
        end else if (clk_en) begin
          acc_q  <= acc_d;
          lfsr_q <= lfsr_d;
        end
      end

      // ---------------- waveform ----------------
      logic        tri_m;
      logic [11:0] tri_w, saw_w, pulse_w, noise_w, wave_sel;
      assign tri_m   = acc_q[23] ^ (ctrl[2] & acc_msb[SRC]);
      assign tri_w   = {tri_m ? ~acc_q[22:12] : acc_q[22:12], 1'b0};
      assign saw_w   = acc_q[23:12];
      assign pulse_w = (acc_q[23:12] >= pw) ? 12'hFFF : 12'h000;
      assign noise_w = {lfsr_q[22], lfsr_q[20], lfsr_q[16], lfsr_q[13],
                        lfsr_q[11], lfsr_q[7], lfsr_q[4], lfsr_q[2], 4'b0000};

      // Selected waveforms combine by AND; no selection gives silence.
      always_comb begin
        wave_sel = 12'hFFF;
        if (ctrl[4]) wave_sel = wave_sel & tri_w;
        if (ctrl[5]) wave_sel = wave_sel & saw_w;
        if (ctrl[6]) wave_sel = wave_sel & pulse_w;
        if (ctrl[7]) wave_sel = wave_sel & noise_w;
        if (ctrl[7:4] == 4'd0) wave_sel = 12'd0;
      end

      // ---------------- envelope ----------------
      logic [1:0]  st_q, st_d;
      logic [7:0]  env_q, env_d;
      logic [14:0] pre_q, pre_d, pre_inc, period;
      logic [3:0]  rate;
      logic        gate_q, tick;

      always_comb begin
        case (st_q)
          ST_ATTACK: rate = ad[7:4];
          ST_DECAY:  rate = ad[3:0];
          default:   rate = sr[3:0];
        endcase
      end
      assign period  = rate_period(rate);
      assign pre_inc = pre_q + 15'd1;
      assign tick    = (pre_inc >= period);

      // Envelope next state: gate edges override any pending step.
      always_comb begin
        st_d  = st_q;
        env_d = env_q;
        pre_d = tick ? 15'd0 : pre_inc;
        if (ctrl[0] && !gate_q) begin
          st_d  = ST_ATTACK;
          pre_d = 15'd0;
        end else if (!ctrl[0] && gate_q) begin
          st_d = ST_RELEASE;
        end else if (tick) begin
          case (st_q)
            ST_ATTACK: begin
              if (env_q == 8'hFF) begin
                st_d = ST_DECAY;
              end else begin
                env_d = env_q + 8'd1;
                if (env_q == 8'hFE) st_d = ST_DECAY;
              end
            end
            ST_DECAY: begin
              if (env_q > {sr[7:4], sr[7:4]}) env_d = env_q - 8'd1;
            end
            default: begin
              if (env_q != 8'd0) env_d = env_q - 8'd1;
            end
          endcase
        end
      end

      // Envelope registers advance on clk_en; the gate is sampled at the same rate.
      always_ff @(posedge clk) begin
        if (rst) begin
          st_q   <= ST_RELEASE;
          env_q  <= 8'd0;
          pre_q  <= 15'd0;
          gate_q <= 1'b0;
        end else if (clk_en) begin
          st_q   <= st_d;
          env_q  <= env_d;
          pre_q  <= pre_d;
          gate_q <= ctrl[0];
        end
      end

      // ---------------- voice amplitude ----------------
      logic [19:0] prod;
      logic        unused_prod;
      assign prod        = {8'd0, wave_sel} * {12'd0, env_q};
      assign voice_v[gi] = prod[19:8];
      assign unused_prod = ^prod[7:0];

`ifdef SID_READBACK_EN
      assign wave_out[gi] = wave_sel;
      assign env_out[gi]  = env_q;
`endif
    end
  endgenerate

  // ---------------- mixer ----------------
  logic [13:0] voice_sum;
  logic [17:0] mix_scaled;
  logic        unused_bits;

  always_comb begin
    voice_sum  = {2'b00, voice_v[0]} + {2'b00, voice_v[1]} + {2'b00, voice_v[2]};
    mix_scaled = {4'd0, voice_sum} * {14'd0, regs_q[24][3:0]};
  end

  assign unused_bits = ^{regs_q[21], regs_q[22], regs_q[23], regs_q[3][7:4],
                         regs_q[10][7:4], regs_q[17][7:4], regs_q[24][7:4], mix_scaled[1:0]};

  // Output sample register, updated every clock.
  always_ff @(posedge clk) begin
    if (rst) audio_out <= 16'd0;
    else     audio_out <= mix_scaled[17:2];
  end

`ifdef SID_READBACK_EN
  // Read port: one-clock registered response; only OSC3 and ENV3 are visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 8'd0;
    end else if (!n_cs && rw) begin
      case (addr)
        5'h1B:   rdata <= wave_out[2][11:4];
        5'h1C:   rdata <= env_out[2];
        default: rdata <= 8'd0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sid_voice_synth.sv
// Testbench for sid_voice_synth: directed scenarios plus randomized register
// traffic, all checked cycle by cycle against a behavioural model.
module tb_sid_voice_synth;

  logic        clk = 1'b0;
  logic        rst, clk_en, n_cs, rw;
  logic [4:0]  addr;
  logic [7:0]  data;
  logic [15:0] audio_out;
`ifdef SID_READBACK_EN
  logic [7:0]  rdata;
`endif

  always #5 clk = ~clk;

  sid_voice_synth dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .addr      (addr),
    .data      (data),
    .n_cs      (n_cs),
    .rw        (rw),
    .audio_out (audio_out)
`ifdef SID_READBACK_EN
    ,
    .rdata     (rdata)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int unsigned SEED = 32'h7FFFF8;
  localparam int PH_ATTACK = 0, PH_DECAY = 1, PH_RELEASE = 2;
  int unsigned PERIOD [16] = '{9, 32, 63, 95, 149, 220, 267, 313,
                               392, 977, 1954, 3126, 3907, 11720, 19532, 31251};

  int unsigned m_reg   [25];
  int unsigned m_acc   [3];
  int unsigned m_lfsr  [3];
  int unsigned m_env   [3];
  int unsigned m_pre   [3];
  int          m_phase [3];
  bit          m_gate  [3];
  int unsigned m_rdata;

  function automatic int unsigned bitof(input int unsigned x, input int p);
    return (x >> p) & 1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 25; i++) m_reg[i] = 0;
    for (int v = 0; v < 3; v++) begin
      m_acc[v] = 0; m_lfsr[v] = SEED; m_env[v] = 0; m_pre[v] = 0;
      m_phase[v] = PH_RELEASE; m_gate[v] = 0;
    end
    m_rdata = 0;
  endfunction

  function automatic int unsigned model_wave(input int v);
    int unsigned ctrl, acc, w, low, msb, pw, nz;
    int taps [8] = '{22, 20, 16, 13, 11, 7, 4, 2};
    ctrl = m_reg[7*v+4];
    acc  = m_acc[v];
    if ((ctrl >> 4) == 0) return 0;
    w = 4095;
    if (bitof(ctrl, 4) == 1) begin
      msb = bitof(acc, 23) ^ (bitof(ctrl, 2) & bitof(m_acc[(v+2)%3], 23));
      low = (acc >> 12) & 'h7FF;
      w &= (msb == 1) ? ('h7FF - low) * 2 : low * 2;
    end
    if (bitof(ctrl, 5) == 1) w &= acc >> 12;
    if (bitof(ctrl, 6) == 1) begin
      pw = m_reg[7*v+2] + 256 * (m_reg[7*v+3] & 15);
      w &= ((acc >> 12) >= pw) ? 4095 : 0;
    end
    if (bitof(ctrl, 7) == 1) begin
      nz = 0;
      for (int k = 0; k < 8; k++) nz += bitof(m_lfsr[v], taps[k]) << (11 - k);
      w &= nz;
    end
    return w;
  endfunction

  function automatic int unsigned model_audio();
    int unsigned sum = 0;
    for (int v = 0; v < 3; v++) sum += (model_wave(v) * m_env[v]) / 256;
    return (sum * (m_reg[24] & 15)) / 4;
  endfunction

  function automatic void model_tick();
    int unsigned nacc [3];
    bit rise [3];
    int unsigned ctrl, per, cnt, sus_lvl;
    bit gate, step;
    for (int v = 0; v < 3; v++) begin
      ctrl = m_reg[7*v+4];
      if (bitof(ctrl, 3) == 1) nacc[v] = 0;
      else nacc[v] = (m_acc[v] + m_reg[7*v] + 256 * m_reg[7*v+1]) & 'hFFFFFF;
      rise[v] = (m_acc[v] < 'h800000) && (nacc[v] >= 'h800000);
    end
    for (int v = 0; v < 3; v++)
      if (bitof(m_reg[7*v+4], 1) == 1 && rise[(v+2)%3]) nacc[v] = 0;
    for (int v = 0; v < 3; v++) begin
      if (bitof(m_reg[7*v+4], 3) == 1)
        m_lfsr[v] = SEED;
      else if (bitof(m_acc[v], 19) == 0 && bitof(nacc[v], 19) == 1)
        m_lfsr[v] = ((m_lfsr[v] << 1) | (bitof(m_lfsr[v], 22) ^ bitof(m_lfsr[v], 17))) & 'h7FFFFF;
      m_acc[v] = nacc[v];
    end
    for (int v = 0; v < 3; v++) begin
      gate = bitof(m_reg[7*v+4], 0) == 1;
      case (m_phase[v])
        PH_ATTACK: per = PERIOD[m_reg[7*v+5] >> 4];
        PH_DECAY:  per = PERIOD[m_reg[7*v+5] & 15];
        default:   per = PERIOD[m_reg[7*v+6] & 15];
      endcase
      cnt  = m_pre[v] + 1;
      step = cnt >= per;
      m_pre[v] = step ? 0 : cnt;
      sus_lvl = (m_reg[7*v+6] >> 4) * 17;
      if (gate && !m_gate[v]) begin
        m_phase[v] = PH_ATTACK;
        m_pre[v] = 0;
      end else if (!gate && m_gate[v]) begin
        m_phase[v] = PH_RELEASE;
      end else if (step) begin
        if (m_phase[v] == PH_ATTACK) begin
          if (m_env[v] < 255) m_env[v]++;
          if (m_env[v] == 255) m_phase[v] = PH_DECAY;
        end else if (m_phase[v] == PH_DECAY) begin
          if (m_env[v] > sus_lvl) m_env[v]--;
        end else begin
          if (m_env[v] > 0) m_env[v]--;
        end
      end
      m_gate[v] = gate;
    end
  endfunction

  // ---------------- stimulus ----------------
  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic cyc(input bit r, input bit en, input bit wr, input bit rd,
                     input int unsigned a, input int unsigned d);
    int unsigned exp_audio;
    rst = r; clk_en = en; n_cs = !(wr || rd); rw = rd;
    addr = a[4:0]; data = d[7:0];
    @(posedge clk);
    if (r) begin
      model_reset();
      exp_audio = 0;
    end else begin
      exp_audio = model_audio();
      if (rd) begin
        if (a == 'h1B)      m_rdata = model_wave(2) >> 4;
        else if (a == 'h1C) m_rdata = m_env[2];
        else                m_rdata = 0;
      end
      if (en) model_tick();
      if (wr && a <= 'h18) m_reg[a] = d;
    end
    #1;
    check("audio", audio_out, exp_audio);
`ifdef SID_READBACK_EN
    check("rdata", rdata, m_rdata);
`endif
    if (wr) $display("write addr=%02h data=%02h audio=%0d", a, d, audio_out);
  endtask

  task automatic wr(input int unsigned a, input int unsigned d);
    cyc(0, 1, 1, 0, a, d);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0);
  endtask

  int unsigned hi_cnt, lo_cnt;

  initial begin
    rst = 1'b1; clk_en = 1'b0; n_cs = 1'b1; rw = 1'b0; addr = '0; data = '0;
    model_reset();

    // Reset held two clocks while a write is attempted
    cyc(1, 1, 1, 0, 'h04, 'h21);
    cyc(1, 1, 1, 0, 'h18, 'h0F);
    cyc(0, 1, 0, 0, 0, 0);
    check("reset_audio", audio_out, 0);
`ifdef SID_READBACK_EN
    for (int a = 0; a < 32; a++) cyc(0, 0, 0, 1, a, 0);
`endif

    // Sawtooth with fast attack, full sustain and volume
    wr('h00, 'h00); wr('h01, 'h10);
    wr('h05, 'h00); wr('h06, 'hF0);
    wr('h18, 'h0F); wr('h04, 'h21);
    run(3000);

    // Pulse at 50% duty with envelope held at 255
    wr('h02, 'h00); wr('h03, 'h08); wr('h04, 'h41);
    hi_cnt = 0; lo_cnt = 0;
    for (int i = 0; i < 4500; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      if (audio_out == 16'd15296) hi_cnt++;
      if (audio_out == 16'd0) lo_cnt++;
    end
    check("pulse_levels", hi_cnt + lo_cnt, 4500);
    check("pulse_duty_hi", (hi_cnt > 2000) && (hi_cnt < 2500), 1);

    // Decay to sustain 0x88, then release to zero and hold
    wr('h06, 'h80);
    run(1500);
    wr('h04, 'h20);
    run(1500);
    wr('h04, 'h21);
    run(3500);

    // TEST holds oscillator, then hard sync from voice 2, then ring-modulated triangle
    wr('h04, 'h29);
    run(300);
    wr('h0E, 'hFF); wr('h0F, 'hFF);
    wr('h04, 'h23);
    run(1500);
    wr('h04, 'h15);
    run(1500);

    // Noise on voice 1
    wr('h07, 'hFF); wr('h08, 'hFF); wr('h0C, 'h00); wr('h0D, 'hF0); wr('h0B, 'h81);
    run(2500);

    // Volume zero with waveforms active; unmapped writes have no effect
    wr('h12, 'h21);
    wr('h18, 'h00);
    run(300);
    check("vol0_audio", audio_out, 0);
    wr('h1D, 'hFF); wr('h19, 'h5A); wr('h1F, 'hA5);
    run(100);
    check("vol0_after_unmapped", audio_out, 0);
    wr('h18, 'h0F);
    run(200);

    // Randomized register traffic with random clk_en and one mid-run reset
    for (int i = 0; i < 20000; i++) begin
      if (i == 10000 || i == 10001) begin
        cyc(1, 1, 1, 0, 'h18, 'h0F);
      end else if ($urandom_range(0, 39) == 0) begin
        cyc(0, $urandom_range(0, 1), 1, 0, $urandom_range(0, 31), $urandom_range(0, 255));
`ifdef SID_READBACK_EN
      end else if ($urandom_range(0, 19) == 0) begin
        cyc(0, $urandom_range(0, 1), 0, 1, $urandom_range(0, 31), 0);
`endif
      end else begin
        cyc(0, $urandom_range(0, 1), 0, 0, 0, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
